// File: rtl/multicycle_proc_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_proc_core: FSM-sequenced 32-bit core with req/ack memory ports.  |
// | Optional macro MULTICYCLE_PROC_ILLEGAL_TRAP_EN: illegal opcode halts core.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module multicycle_proc_core #(
    parameter int                DBITS               = 32,
    parameter int                REG_INDEX_BIT_WIDTH = 4,
    parameter logic [DBITS-1:0]  START_PC            = 'h40,
    parameter int                INST_BIT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req,
    output logic [DBITS-1:0]          imem_addr,
    input  logic                      imem_ack,
    input  logic [INST_BIT_WIDTH-1:0] imem_rdata,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DBITS-1:0]          dmem_addr,
    output logic [DBITS-1:0]          dmem_wdata,
    input  logic                      dmem_ack,
    input  logic [DBITS-1:0]          dmem_rdata,
    output logic                      retire,
    output logic                      halted
);
    localparam int RW    = REG_INDEX_BIT_WIDTH;
    localparam int NREGS = 2 ** RW;

    localparam logic [3:0] OP_ALUR  = 4'b0000;
    localparam logic [3:0] OP_ALUI  = 4'b1000;
    localparam logic [3:0] OP_CMPR  = 4'b0010;
    localparam logic [3:0] OP_CMPI  = 4'b1010;
    localparam logic [3:0] OP_BCOND = 4'b0110;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b1001;
    localparam logic [3:0] OP_JAL   = 4'b1011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                      state, state_nxt;
    logic                        run;
    logic [DBITS-1:0]            pc, a_val, b_val, res, npc;
    logic [INST_BIT_WIDTH-1:0]   ir;
    logic                        wr_en;
    logic [DBITS-1:0]            regs [NREGS];

    logic [3:0]       op1, op2;
    logic [RW-1:0]    rd, rs1, rs2;
    logic [DBITS-1:0] imm_sext, br_off, pc_plus4;
    logic [DBITS-1:0] alu_b, cmp_b, alu_res, res_nxt, npc_nxt;
    logic             alu_ok, cmp_ok, cmp_res, eq, lt, wr_nxt, illegal, is_sw, is_mem;

    assign op1      = ir[31:28];
    assign op2      = ir[27:24];
    assign rd       = ir[20 +: RW];
    assign rs1      = ir[16 +: RW];
    assign rs2      = ir[12 +: RW];
    assign imm_sext = DBITS'($signed(ir[15:0]));
    assign br_off   = imm_sext << 2;
    assign pc_plus4 = pc + DBITS'(4);
    assign is_sw    = (op1 == OP_SW);
    assign is_mem   = (op1 == OP_SW) || (op1 == OP_LW);

    assign alu_b = (op1 == OP_ALUI) ? imm_sext : b_val;
    assign cmp_b = (op1 == OP_CMPI) ? imm_sext : b_val;
    assign eq    = (a_val == cmp_b);
    assign lt    = ($signed(a_val) < $signed(cmp_b));

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (op2)
            4'b0000: alu_res = a_val + alu_b;
            4'b0001: alu_res = a_val - alu_b;
            4'b0100: alu_res = a_val & alu_b;
            4'b0101: alu_res = a_val | alu_b;
            4'b0110: alu_res = a_val ^ alu_b;
            4'b1100: alu_res = ~(a_val & alu_b);
            4'b1101: alu_res = ~(a_val | alu_b);
            4'b1110: alu_res = ~(a_val ^ alu_b);
            default: alu_ok  = 1'b0;
        endcase
    end

    always_comb begin
        cmp_res = 1'b0;
        cmp_ok  = 1'b1;
        case (op2)
            4'b0000: cmp_res = 1'b0;
            4'b0001: cmp_res = eq;
            4'b0010: cmp_res = lt;
            4'b0011: cmp_res = lt | eq;
            4'b1000: cmp_res = 1'b1;
            4'b1001: cmp_res = ~eq;
            4'b1010: cmp_res = ~lt;
            4'b1011: cmp_res = ~(lt | eq);
            default: cmp_ok  = 1'b0;
        endcase
    end

    // Illegal instructions fall through as NOPs: no write, PC+4.
    always_comb begin
        res_nxt = alu_res;
        npc_nxt = pc_plus4;
        wr_nxt  = 1'b0;
        illegal = 1'b0;
        case (op1)
            OP_ALUR, OP_ALUI: begin
                wr_nxt  = alu_ok;
                illegal = ~alu_ok;
            end
            OP_CMPR, OP_CMPI: begin
                res_nxt = {{(DBITS-1){1'b0}}, cmp_res};
                wr_nxt  = cmp_ok;
                illegal = ~cmp_ok;
            end
            OP_BCOND: begin
                illegal = ~cmp_ok;
                if (cmp_ok && cmp_res) npc_nxt = pc_plus4 + br_off;
            end
            OP_SW, OP_LW: begin
                res_nxt = a_val + imm_sext;
                wr_nxt  = (op1 == OP_LW);
            end
            OP_JAL: begin
                res_nxt = pc_plus4;
                npc_nxt = a_val + br_off;
                wr_nxt  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = run;
                if (run && imem_ack) state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
`ifdef MULTICYCLE_PROC_ILLEGAL_TRAP_EN
                if (illegal)     state_nxt = S_HALT;
                else if (is_mem) state_nxt = S_MEM;
                else             state_nxt = S_WB;
`else
                state_nxt = is_mem ? S_MEM : S_WB;
`endif
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ack) state_nxt = S_WB;
            end
            S_WB: begin
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
`ifdef MULTICYCLE_PROC_ILLEGAL_TRAP_EN
            S_HALT:  halted = 1'b1;
`else
            S_HALT:  state_nxt = S_FETCH;
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    assign imem_addr  = pc;
    assign dmem_addr  = dmem_req ? res : '0;
    assign dmem_wdata = dmem_we ? b_val : '0;

    // run holds off the first fetch until one cycle after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run   <= 1'b0;
            pc    <= START_PC;
            ir    <= '0;
            a_val <= '0;
            b_val <= '0;
            res   <= '0;
            npc   <= '0;
            wr_en <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                S_FETCH:  if (run && imem_ack) ir <= imem_rdata;
                S_DECODE: begin
                    a_val <= regs[rs1];
                    b_val <= ((op1 == OP_ALUR) || (op1 == OP_CMPR)) ? regs[rs2] : regs[rd];
                end
                S_EXEC: begin
                    res   <= res_nxt;
                    npc   <= npc_nxt;
                    wr_en <= wr_nxt;
                end
                S_MEM:    if (dmem_ack && !is_sw) res <= dmem_rdata;
                S_WB: begin
                    if (wr_en) regs[rd] <= res;
                    pc <= npc;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_multicycle_proc_core.sv
`default_nettype none
// Directed bench for multicycle_proc_core with req/ack memory responders.
module tb_multicycle_proc_core;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        retire, halted;

    int vectors = 0;
    int miscompares = 0;

    int imem_wait = 0, dmem_wait = 0;
    int icnt = 0, dcnt = 0, iviol = 0, dviol = 0, store_cnt = 0, exp_stores = 0;
    logic        ipend = 0, dpend = 0;
    logic [31:0] ipend_addr, dpend_addr, dpend_wdata, last_fetch, st_addr, st_data;
    logic        dpend_we;
    logic [31:0] dm [logic [31:0]];

    multicycle_proc_core dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] prog(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h8010_0005; // ADDI R1,R0,5
            32'h44:  return 32'h8020_03FF; // ADDI R2,R0,0x3FF
            32'h48:  return 32'h9050_0000; // LW   R5,0(R0)
            32'h4C:  return 32'h5025_0004; // SW   R2,4(R5)
            32'h50:  return 32'h6111_0002; // BEQ  R1,R1,+2
            32'h5C:  return 32'h9035_0004; // LW   R3,4(R5)
            32'h60:  return 32'h5035_0008; // SW   R3,8(R5)
            32'h64:  return 32'h6911_0002; // BNE  R1,R1,+2
            32'h68:  return 32'h8040_0100; // ADDI R4,R0,0x100
            32'h6C:  return 32'hB0F4_0000; // JAL  R15,R4,0
            32'h100: return 32'h50F5_0000; // SW   R15,0(R5)
            32'h104: return 32'h0161_2000; // SUB  R6,R1,R2
            32'h108: return 32'h2276_1000; // LT   R7,R6,R1
            32'h10C: return 32'h5075_0000; // SW   R7,0(R5)
            32'h110: return 32'h5065_0004; // SW   R6,4(R5)
            32'h114: return 32'hAB81_0004; // GTI  R8,R1,4
            32'h118: return 32'h5085_0008; // SW   R8,8(R5)
            32'h11C: return 32'hF000_0000; // illegal op1
            32'h120: return 32'h5015_0000; // SW   R1,0(R5)
            default: return 32'h0000_0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (imem_req) begin
            if (ipend && imem_addr !== ipend_addr) iviol++;
            if (icnt == imem_wait) begin
                imem_ack = 1'b1; imem_rdata = prog(imem_addr); last_fetch = imem_addr;
                icnt = 0; ipend = 1'b0;
            end else begin
                imem_ack = 1'b0; icnt++; ipend = 1'b1; ipend_addr = imem_addr;
            end
        end else begin
            imem_ack = 1'b0; icnt = 0; ipend = 1'b0;
        end
        if (dmem_req) begin
            if (dpend && (dmem_addr !== dpend_addr || dmem_we !== dpend_we || dmem_wdata !== dpend_wdata))
                dviol++;
            if (dcnt == dmem_wait) begin
                dmem_ack = 1'b1; dcnt = 0; dpend = 1'b0;
                if (dmem_we) begin
                    dm[dmem_addr] = dmem_wdata; st_addr = dmem_addr; st_data = dmem_wdata; store_cnt++;
                end else begin
                    dmem_rdata = dm.exists(dmem_addr) ? dm[dmem_addr] : 32'h0;
                end
            end else begin
                dmem_ack = 1'b0; dcnt++; dpend = 1'b1;
                dpend_addr = dmem_addr; dpend_we = dmem_we; dpend_wdata = dmem_wdata;
            end
        end else begin
            dmem_ack = 1'b0; dcnt = 0; dpend = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] exp_fetch, input int exp_cyc);
        int cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (retire === 1'b1) begin
                cyc = i;
                break;
            end
        end
        check({tag, " cycles"}, cyc, exp_cyc);
        check({tag, " fetch"}, last_fetch, exp_fetch);
    endtask

    task automatic check_store(input string tag, input logic [31:0] addr, input logic [31:0] data);
        exp_stores++;
        check({tag, " count"}, store_cnt, exp_stores);
        check({tag, " addr"}, st_addr, addr);
        check({tag, " data"}, st_data, data);
    endtask

    initial begin
        int seen;
        reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_rdata = '0; dmem_rdata = '0;
        dm[32'h0] = 32'hF000_0000;
        repeat (3) @(negedge clk);
        check("rst imem_req", imem_req, 0);
        check("rst dmem_req", dmem_req, 0);
        check("rst retire", retire, 0);
        check("rst halted", halted, 0);
        check("rst dmem_addr", dmem_addr, 0);
        check("rst dmem_we", dmem_we, 0);
        check("rst imem_addr", imem_addr, 32'h40);
        @(negedge clk);
        reset = 1'b0;
        #1 check("req after release", imem_req, 0);

        step("addi_r1", 32'h40, 4);
        imem_wait = 3;
        step("addi_r2 slow", 32'h44, 7);
        imem_wait = 0;
        check("imem stable", iviol, 0);
        step("lw_r5", 32'h48, 5);
        step("sw_r2", 32'h4C, 5);
        check_store("sw_r2", 32'hF000_0004, 32'h3FF);
        step("beq", 32'h50, 4);
        step("lw_r3", 32'h5C, 5);
        step("sw_r3", 32'h60, 5);
        check_store("sw_r3", 32'hF000_0008, 32'h3FF);
        step("bne", 32'h64, 4);
        step("addi_r4", 32'h68, 4);
        step("jal", 32'h6C, 4);
        step("sw_r15", 32'h100, 5);
        check_store("sw_r15", 32'hF000_0000, 32'h70);
        step("sub", 32'h104, 4);
        step("cmp_lt", 32'h108, 4);
        step("sw_r7", 32'h10C, 5);
        check_store("sw_r7", 32'hF000_0000, 32'h1);
        step("sw_r6", 32'h110, 5);
        check_store("sw_r6", 32'hF000_0004, 32'hFFFF_FC06);
        step("cmpi_gt", 32'h114, 4);
        step("sw_r8", 32'h118, 5);
        check_store("sw_r8", 32'hF000_0008, 32'h1);

`ifdef MULTICYCLE_PROC_ILLEGAL_TRAP_EN
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (halted === 1'b1) break;
        end
        check("halted", halted, 1);
        check("halt fetch", last_fetch, 32'h11C);
        check("halt pc", imem_addr, 32'h11C);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) seen++;
        end
        check("halt quiet", seen, 0);
`else
        step("illegal nop", 32'h11C, 4);
        check("no halt", halted, 0);
        step("sw_r1", 32'h120, 5);
        check_store("sw_r1", 32'hF000_0000, 32'h5);
`endif

        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst2 halted", halted, 0);
        check("rst2 pc", imem_addr, 32'h40);
        reset = 1'b0;
        dmem_wait = 6;
        step("addi_r1 again", 32'h40, 4);
        step("addi_r2 again", 32'h44, 4);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dmem_req === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("mem wait req", seen, 1);
        repeat (2) @(negedge clk);
        check("mem wait held", dmem_req, 1);
        #2 reset = 1'b1;
        #1 check("mid-mem dmem_req", dmem_req, 0);
        check("mid-mem imem_req", imem_req, 0);
        check("mid-mem pc", imem_addr, 32'h40);
        @(negedge clk);
        reset = 1'b0;
        dmem_wait = 0;
        step("after mem reset", 32'h40, 4);
        check("dmem stable", dviol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
`default_nettype wire
